// File: rtl/match_timer_m.sv
// High-digit stage behind counter_M: counts low-digit carries modulo N, compares the
// combined {count_hi,count_lo} against a target, and reports match/done/overflow/cfg_err.
//
// state | meaning
// IDLE  | stopped; count_hi held; waits for arm
// RUN   | counting carries and comparing against the target
// HOLD  | matched; count_hi frozen; done held until arm or reset
module match_timer_m #(
  parameter int M    = 10,
  parameter int N    = 16,
  parameter int HI_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            carry_in,
  input  logic [3:0]      count_lo,
  input  logic            arm,
  input  logic            stop,
  input  logic [HI_W-1:0] match_hi,
  input  logic [3:0]      match_lo,
  output logic [HI_W-1:0] count_hi,
  output logic            match_pulse,
  output logic            done,
  output logic            busy,
  output logic            overflow,
  output logic            cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  // Limits are widened by one bit so that M = 16 or N = 2**HI_W still compare correctly.
  localparam logic [4:0]    M_LIM = M[4:0];
  localparam logic [HI_W:0] N_LIM = N[HI_W:0];

  state_t          state, state_nxt;
  logic [HI_W-1:0] hi_nxt;
  logic            pulse_nxt, done_nxt, ovf_nxt, cfg_nxt;
  logic            hit, hi_last;

  assign hi_last = (count_hi == HI_W'(N - 1));
  assign hit     = enable && !cfg_err && (count_hi == match_hi) && (count_lo == match_lo);
  assign cfg_nxt = ({1'b0, match_lo} >= M_LIM) || ({1'b0, match_hi} >= N_LIM);
  assign busy    = (state == RUN);

  always_comb begin
    state_nxt = state;
    hi_nxt    = count_hi;
    pulse_nxt = 1'b0;
    done_nxt  = done;
    ovf_nxt   = overflow;
    if (arm) begin
      state_nxt = RUN;
      hi_nxt    = '0;
      done_nxt  = 1'b0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stop) begin
            state_nxt = IDLE;
          end else begin
            // a carry coinciding with the hit still advances the high digit
            if (enable && carry_in) begin
              hi_nxt = hi_last ? '0 : count_hi + HI_W'(1);
              if (hi_last) ovf_nxt = 1'b1;
            end
            if (hit) begin
              pulse_nxt = 1'b1;
              done_nxt  = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (stop) state_nxt = IDLE;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count_hi    <= '0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      count_hi    <= hi_nxt;
      match_pulse <= pulse_nxt;
      done        <= done_nxt;
      overflow    <= ovf_nxt;
      cfg_err     <= cfg_nxt;
    end
  end

endmodule
